// File: rtl/hxd_pkg.sv
// Shared types and constants for the instruction fetch path.
package hxd_pkg;

  localparam int FETCH_XLEN       = 32;
  localparam int INST_WIDTH_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; simultaneous push and pop is allowed when full.
module sync_fifo
  import hxd_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full queue needs for the push.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifu_pfq.sv
// Instruction fetch unit with a prefetch queue: issues sequential IRAM reads
// ahead of decode, buffers {pc, inst} pairs and flushes on an EXU redirect.
module ifu_pfq
  import hxd_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     redirect_en_i,
  input  logic [XLEN-1:0]          redirect_addr_i,
  output logic                     iram_rd_en_o,
  output logic [XLEN-1:0]          iram_rd_addr_o,
  input  logic [XLEN-1:0]          iram_rd_data_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [XLEN-1:0]          inst_data_o,
  output logic [XLEN-1:0]          inst_pc_o,
  output logic [XLEN-1:0]          inst_pc_next_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_WIDTH_BYTES);
  localparam logic [LW:0]     DEPTH_W = (LW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   inflight_pc_q;
  logic [XLEN-1:0]   redirect_pc;
  logic              inflight_q;
  logic              issue, pop, push, credit_ok;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              unused_addr_bits;

  assign redirect_pc      = {redirect_addr_i[XLEN-1:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr_i[1:0];

  // Credit rule: queued plus in-flight entries never exceed DEPTH, so a
  // returning read always has a slot.
  assign credit_ok = ({1'b0, count} + {{LW{1'b0}}, inflight_q}) < DEPTH_W;
  assign pop       = inst_valid_o & inst_ready_i;
  assign issue     = rst_n_i & ~redirect_en_i & (credit_ok | pop);
  assign push      = inflight_q & ~redirect_en_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en_i) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_en_i),
    .data_i  ({inflight_pc_q, iram_rd_data_i}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                   !(push && fifo_full && !pop));

  assign iram_rd_en_o   = issue;
  assign iram_rd_addr_o = fetch_pc_q;
  assign inst_valid_o   = ~fifo_empty;
  assign inst_pc_o      = head[2*XLEN-1:XLEN];
  assign inst_data_o    = head[XLEN-1:0];
  assign inst_pc_next_o = head[2*XLEN-1:XLEN] + PC_STEP;
  assign level_o        = count;

endmodule
